// File: rtl/ff_arb_pkg.sv
// ----------------------------------------------------------------------------
// ff_arb_pkg
//   Shared types and helpers for the shared-register write arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, GRANT)
//   - MAX_REQ     : widest requester vector the helper function handles
//   - MAX_IDX_W   : index width matching MAX_REQ
//   - rr_pick()   : round-robin pick of one requester, returned one-hot
// ----------------------------------------------------------------------------
package ff_arb_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    // IDLE waits for an enabled request; GRANT holds a live one-hot grant
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Rotate the available requests so that ptr sits at position 0, take the
    // first set bit, then map that position back to its real requester index.
    // The three steps are folded into one scan over k = 0 .. num_req-1, where
    // position k of the rotated vector is requester (ptr + k) mod num_req.
    // Bits above num_req-1 are never selected.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_REQ-1:0]   mask,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   num_req
    );
        logic [MAX_REQ-1:0] avail;
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int                 idx;
        avail = req & ~mask;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if ((k < num_req) && !found && avail[idx[MAX_IDX_W-1:0]]) begin
                pick[idx[MAX_IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin selector: rotate by ptr, priority-encode,
//   unrotate. Masked requesters are never chosen.
//   Ports:
//     req    in  NUM_REQ  raw requests
//     mask   in  NUM_REQ  requesters excluded from this pick
//     ptr    in  IDX_W    requester with highest priority this pick
//     onehot out NUM_REQ  one-hot winner (all zero when nothing is eligible)
//     index  out IDX_W    binary index of the winner (0 when none)
//     found  out 1        a winner exists
// ----------------------------------------------------------------------------
module rr_priority_pick
    import ff_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] mask_ext;
    logic [MAX_REQ-1:0] pick_ext;

    // Widen to the helper's fixed width; the upper bits are zero so the
    // helper can never pick them.
    assign req_ext  = MAX_REQ'(req);
    assign mask_ext = MAX_REQ'(mask);
    assign pick_ext = rr_pick(req_ext, mask_ext, MAX_IDX_W'(ptr), NUM_REQ);

    assign onehot = pick_ext[NUM_REQ-1:0];
    assign found  = |pick_ext;

    // One-hot to binary conversion of the winner
    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ff_write_arbiter.sv
// ----------------------------------------------------------------------------
// ff_write_arbiter
//   Round-robin arbiter sharing one clock-enabled DATA_W-bit register among
//   NUM_REQ requesters. A winner gets a registered one-hot grant for a single
//   cycle; the register loads that requester's data at the end of the cycle.
//   Ports:
//     CK       in  1               clock, rising edge
//     SR       in  1               synchronous active-high reset
//     en       in  1               global enable, 0 blocks new grants
//     req      in  NUM_REQ         request per requester
//     req_data in  NUM_REQ*DATA_W  flat data, requester i at [i*DATA_W +: DATA_W]
//     gnt      out NUM_REQ         registered one-hot grant, one-cycle pulse
//     Q        out DATA_W          shared register
//     wr_valid out 1               Q was loaded at the last edge
//     wr_id    out $clog2(NUM_REQ) requester whose data is in Q
// ----------------------------------------------------------------------------
module ff_write_arbiter
    import ff_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                       CK,
    input  logic                       SR,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [DATA_W-1:0]          Q,
    output logic                       wr_valid,
    output logic [$clog2(NUM_REQ)-1:0] wr_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state;
    arb_state_t         next_state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   gnt_id;
    logic [IDX_W-1:0]   next_gnt_id;
    logic [NUM_REQ-1:0] next_gnt;
    logic [NUM_REQ-1:0] pick_mask;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_index;
    logic               pick_found;
    logic [DATA_W-1:0]  sel_data;

    // The live grantee is excluded from the next pick, so nobody is granted
    // in two consecutive cycles even while its req is still high.
    assign pick_mask = (state == GRANT) ? gnt : '0;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_index),
        .found  (pick_found)
    );

    // Next-state logic: a new grant needs both an eligible winner and en.
    // On a grant the pointer moves just past the winner.
    always_comb begin
        next_state  = IDLE;
        next_gnt    = '0;
        next_gnt_id = gnt_id;
        next_ptr    = ptr;
        case (state)
            IDLE: begin
                if (en && pick_found) begin
                    next_state  = GRANT;
                    next_gnt    = pick_onehot;
                    next_gnt_id = pick_index;
                    next_ptr    = (pick_index == IDX_W'(NUM_REQ - 1)) ? '0 : pick_index + 1'b1;
                end
            end
            GRANT: begin
                if (en && pick_found) begin
                    next_state  = GRANT;
                    next_gnt    = pick_onehot;
                    next_gnt_id = pick_index;
                    next_ptr    = (pick_index == IDX_W'(NUM_REQ - 1)) ? '0 : pick_index + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, pointer and grant registers
    always_ff @(posedge CK) begin
        if (SR) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= next_state;
            ptr    <= next_ptr;
            gnt    <= next_gnt;
            gnt_id <= next_gnt_id;
        end
    end

    // Data of the current grantee; other requesters' data is never looked at
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Shared register with CE = |gnt. A grant still completes its write when
    // en drops; reset during a grant cycle discards the write.
    always_ff @(posedge CK) begin
        if (SR) begin
            Q        <= '0;
            wr_id    <= '0;
            wr_valid <= 1'b0;
        end else if (|gnt) begin
            Q        <= sel_data;
            wr_id    <= gnt_id;
            wr_valid <= 1'b1;
        end else begin
            wr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ff_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ff_write_arbiter
//   Directed self-checking bench for ff_write_arbiter (NUM_REQ=4, DATA_W=8).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_ff_write_arbiter;

    logic        CK;
    logic        SR;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  Q;
    logic        wr_valid;
    logic [1:0]  wr_id;

    int checks;
    int fails;

    ff_write_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
    ) dut (
        .CK       (CK),
        .SR       (SR),
        .en       (en),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .Q        (Q),
        .wr_valid (wr_valid),
        .wr_id    (wr_id)
    );

    // 10-unit clock
    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // One reset edge, leaving all inputs idle
    task automatic do_reset();
        SR  = 1'b1;
        en  = 1'b1;
        req = 4'b0000;
        step();
        SR  = 1'b0;
    endtask

    // Reset held two edges with all requests high
    task automatic test_reset();
        SR       = 1'b1;
        en       = 1'b1;
        req      = 4'b1111;
        req_data = 32'hDDCC_BBAA;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (gnt !== 4'b0000) begin
                fails++;
                $display("[TB] FAIL reset_gnt cycle %0d: got %b expected 0000", c, gnt);
            end
            checks++;
            if (Q !== 8'h00) begin
                fails++;
                $display("[TB] FAIL reset_q cycle %0d: got %h expected 00", c, Q);
            end
            checks++;
            if (wr_valid !== 1'b0 || wr_id !== 2'd0) begin
                fails++;
                $display("[TB] FAIL reset_wr cycle %0d: got valid=%b id=%0d expected valid=0 id=0", c, wr_valid, wr_id);
            end
        end
        SR = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL reset_first_gnt: got %b expected 0001", gnt);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    // Lone requester 2 from idle
    task automatic test_single();
        do_reset();
        req_data = 32'h00A5_0000;
        req      = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || wr_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_gnt: got gnt=%b valid=%b expected gnt=0100 valid=0", gnt, wr_valid);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL single_gnt_drop: got %b expected 0000", gnt);
        end
        checks++;
        if (Q !== 8'hA5 || wr_id !== 2'd2 || wr_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_write: got Q=%h id=%0d valid=%b expected Q=a5 id=2 valid=1", Q, wr_id, wr_valid);
        end
        step();
        checks++;
        if (wr_valid !== 1'b0 || Q !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL single_pulse: got valid=%b Q=%h expected valid=0 Q=a5", wr_valid, Q);
        end
    endtask

    // All four requesting: back-to-back rotation
    task automatic test_round_robin();
        logic [3:0] exp_g  [0:4];
        logic [7:0] exp_q  [0:4];
        logic [1:0] exp_id [0:4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_q[0] = 8'h00; exp_q[1] = 8'h11; exp_q[2] = 8'h22;
        exp_q[3] = 8'h33; exp_q[4] = 8'h00;
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2;
        exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        do_reset();
        req_data = 32'h3322_1100;
        req      = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k < 5) begin
                checks++;
                if (gnt !== exp_g[k]) begin
                    fails++;
                    $display("[TB] FAIL rr_gnt step %0d: got %b expected %b", k, gnt, exp_g[k]);
                end
            end
            if (k > 0) begin
                checks++;
                if (Q !== exp_q[k-1] || wr_id !== exp_id[k-1] || wr_valid !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL rr_write step %0d: got Q=%h id=%0d valid=%b expected Q=%h id=%0d valid=1",
                             k, Q, wr_id, wr_valid, exp_q[k-1], exp_id[k-1]);
                end
            end
        end
        req = 4'b0000;
        step();
        step();
    endtask

    // Requester 1 alone, held 10 cycles: grant every other cycle
    task automatic test_back_to_back();
        int gcount;
        int wcount;
        gcount = 0;
        wcount = 0;
        do_reset();
        req_data = 32'h0000_5A00;
        req      = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (gnt[1]) gcount++;
            if (wr_valid) wcount++;
            checks++;
            if (gnt !== ((k % 2 == 1) ? 4'b0010 : 4'b0000)) begin
                fails++;
                $display("[TB] FAIL same_req_gnt cycle %0d: got %b expected %b", k, gnt,
                         (k % 2 == 1) ? 4'b0010 : 4'b0000);
            end
            if (k % 2 == 0) begin
                checks++;
                if (wr_valid !== 1'b1 || Q !== 8'h5A || wr_id !== 2'd1) begin
                    fails++;
                    $display("[TB] FAIL same_req_write cycle %0d: got valid=%b Q=%h id=%0d expected valid=1 Q=5a id=1",
                             k, wr_valid, Q, wr_id);
                end
            end
        end
        checks++;
        if (gcount != 5 || wcount != 5) begin
            fails++;
            $display("[TB] FAIL same_req_counts: got grants=%0d writes=%0d expected 5 and 5", gcount, wcount);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    // en low blocks new grants but not a grant already issued
    task automatic test_enable();
        do_reset();
        req_data = 32'h0000_E7C3;
        req      = 4'b0001;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (Q !== 8'hC3 || wr_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL en_setup: got Q=%h valid=%b expected Q=c3 valid=1", Q, wr_valid);
        end
        en  = 1'b0;
        req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (gnt !== 4'b0000 || wr_valid !== 1'b0 || Q !== 8'hC3) begin
                fails++;
                $display("[TB] FAIL en_blocked cycle %0d: got gnt=%b valid=%b Q=%h expected gnt=0000 valid=0 Q=c3",
                         k, gnt, wr_valid, Q);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL en_resume_gnt: got %b expected 0010", gnt);
        end
        en  = 1'b0;
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || wr_valid !== 1'b1 || Q !== 8'hE7 || wr_id !== 2'd1) begin
            fails++;
            $display("[TB] FAIL en_complete: got gnt=%b valid=%b Q=%h id=%0d expected gnt=0000 valid=1 Q=e7 id=1",
                     gnt, wr_valid, Q, wr_id);
        end
        en = 1'b1;
        step();
    endtask

    // Reset landing on a grant cycle aborts the write
    task automatic test_reset_abort();
        do_reset();
        req_data = 32'h3C00_0077;
        req      = 4'b0001;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (Q !== 8'h77) begin
            fails++;
            $display("[TB] FAIL abort_setup: got Q=%h expected 77", Q);
        end
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000) begin
            fails++;
            $display("[TB] FAIL abort_gnt: got %b expected 1000", gnt);
        end
        SR  = 1'b1;
        req = 4'b0000;
        step();
        checks++;
        if (Q !== 8'h00 || wr_valid !== 1'b0 || gnt !== 4'b0000 || wr_id !== 2'd0) begin
            fails++;
            $display("[TB] FAIL abort_reset: got Q=%h valid=%b gnt=%b id=%0d expected Q=00 valid=0 gnt=0000 id=0",
                     Q, wr_valid, gnt, wr_id);
        end
        SR  = 1'b0;
        req = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL abort_restart: got %b expected 0001", gnt);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    // Run every scenario in order, then report
    initial begin
        checks   = 0;
        fails    = 0;
        SR       = 1'b1;
        en       = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_enable();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
